// File: rtl/seg_display_scanner_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package seg_pkg;

  // Active-low cathodes, bit 0 = segment a ... bit 6 = segment g
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  // Active-low glyphs for hex digits 0..F
  localparam seg_t HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  // Table lookup of the glyph for this nibble
  assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/seg_display_scanner.sv
// 8-digit multiplexed 7-segment scanner with anti-ghost blanking,
// leading-zero suppression and per-digit enable.
//
//   state | meaning
//   BLANK | all anodes off for BLANK_TICKS cycles; inputs snapshotted on the last cycle
//   SHOW  | digit idx driven from the snapshot for the remainder of the slot
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100_000,
  parameter int BLANK_TICKS     = 1_000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int CW = $clog2(TICKS_PER_DIGIT);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - BLANK_TICKS - 1);

  scan_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic          snap_load;

  logic [31:0]   snap_value;
  logic [7:0]    snap_en;
  logic [7:0]    snap_dp;
  logic          snap_lz;

  seg_t          glyph;
  logic          lz_sup;
  logic [7:0]    an_d;
  seg_t          seg_d;
  logic          dp_d;

  // State, tick counter and digit index registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

  // Phase sequencing: the counter restarts on every phase change
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    idx_d     = idx;
    snap_load = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_d   = SHOW;
          cnt_d     = '0;
          snap_load = 1'b1;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx + 1'b1;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Input snapshot so a slot shows a stable value even if inputs move mid-slot
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      snap_value <= '0;
      snap_en    <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
    end else if (snap_load) begin
      snap_value <= value;
      snap_en    <= digit_en;
      snap_dp    <= dp_mask;
      snap_lz    <= lz_blank;
    end
  end

  hex_to_seg u_hex_to_seg (
    .nib (snap_value[{idx, 2'b00} +: 4]),
    .seg (glyph)
  );

  // Digit idx is a leading zero when it and every digit to its left are zero
  assign lz_sup = snap_lz && (idx != 3'd0) && ((snap_value >> {idx, 2'b00}) == 32'd0);

  // Next output values for the current phase and digit
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state == SHOW && snap_en[idx]) begin
      if (lz_sup) begin
        if (snap_dp[idx]) begin
          an_d[idx] = 1'b0;
          dp_d      = 1'b0;
        end
      end else begin
        an_d[idx] = 1'b0;
        seg_d     = glyph;
        dp_d      = ~snap_dp[idx];
      end
    end
  end

  // Registered outputs; reset forces the display dark immediately
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed, table-driven bench for seg_display_scanner with a short slot timing.
module tb_seg_display_scanner;

  localparam int TPD = 10;
  localparam int BT  = 2;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] value  = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  dp_mask  = 8'h00;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  seg_display_scanner #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BT)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .value    (value),
    .digit_en (digit_en),
    .dp_mask  (dp_mask),
    .lz_blank (lz_blank),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  // lit: digits whose anode goes low; segs: glyph per digit (d7..d0); dpl: active-low dp when lit
  typedef struct {
    logic [31:0]     value;
    logic [7:0]      en;
    logic [7:0]      dpm;
    logic            lz;
    logic [7:0]      lit;
    logic [7:0][6:0] segs;
    logic [7:0]      dpl;
  } vec_t;

  vec_t vecs [8];
  vec_t vm, vm2;

  function automatic vec_t mk(logic [31:0] v, logic [7:0] en, logic [7:0] dpm, logic lz,
                              logic [7:0] lit, logic [55:0] segs, logic [7:0] dpl);
    vec_t r;
    r.value = v; r.en = en; r.dpm = dpm; r.lz = lz;
    r.lit = lit; r.segs = segs; r.dpl = dpl;
    return r;
  endfunction

  // Expected {an, seg, dp} after posedge c counted from reset release
  function automatic logic [15:0] expect_at(vec_t v, int c);
    int ph, d;
    logic [7:0] a;
    if (c < 3) return {8'hFF, 7'h7F, 1'b1};
    ph = (c - 3) % TPD;
    d  = ((c - 3) / TPD) % 8;
    if (ph >= TPD - BT || !v.lit[d]) return {8'hFF, 7'h7F, 1'b1};
    a = 8'hFF;
    a[d] = 1'b0;
    return {a, v.segs[d], v.dpl[d]};
  endfunction

  task automatic check(string name, logic [15:0] exp);
    logic [15:0] act;
    act = {an, seg, dp};
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20)
        $display("FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 name, act[15:8], act[7:1], act[0], exp[15:8], exp[7:1], exp[0]);
    end
  endtask

  // Assert reset away from the clock edge, load inputs, release on a negedge
  task automatic start(vec_t v);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    check("reset_state", {8'hFF, 7'h7F, 1'b1});
    value = v.value; digit_en = v.en; dp_mask = v.dpm; lz_blank = v.lz;
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic step(string tag, vec_t v, int c);
    @(posedge clk_in);
    #1;
    check($sformatf("%s_c%0d", tag, c), expect_at(v, c));
  endtask

  initial begin
    vecs[0] = mk(32'h0000_00A5, 8'hFF, 8'h00, 1'b0, 8'hFF,
                 {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h08,7'h12}, 8'hFF);
    vecs[1] = mk(32'h0000_00A5, 8'hFF, 8'h00, 1'b1, 8'h03,
                 {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h08,7'h12}, 8'hFF);
    vecs[2] = mk(32'h0000_0000, 8'hFF, 8'h00, 1'b1, 8'h01,
                 {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 8'hFF);
    vecs[3] = mk(32'h0000_00A5, 8'hFE, 8'h00, 1'b0, 8'hFE,
                 {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h08,7'h7F}, 8'hFF);
    vecs[4] = mk(32'h0000_0005, 8'hFF, 8'h04, 1'b1, 8'h05,
                 {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h12}, 8'hFB);
    vecs[5] = mk(32'h89AB_CDEF, 8'hFF, 8'h81, 1'b1, 8'hFF,
                 {7'h00,7'h10,7'h08,7'h03,7'h46,7'h21,7'h06,7'h0E}, 8'h7E);
    vecs[6] = mk(32'h0123_4567, 8'hFF, 8'h00, 1'b1, 8'h7F,
                 {7'h7F,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78}, 8'hFF);
    vecs[7] = mk(32'h0010_0000, 8'hFF, 8'h80, 1'b1, 8'hBF,
                 {7'h7F,7'h7F,7'h79,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'h7F);

    // Full frame plus wrap into the next frame for every vector
    for (int i = 0; i < 8; i++) begin
      start(vecs[i]);
      for (int c = 1; c <= 90; c++) step($sformatf("v%0d", i), vecs[i], c);
    end

    // Reset asserted mid-SHOW clears outputs at once; restart timing from release
    start(vecs[0]);
    for (int c = 1; c <= 5; c++) step("pre_rst", vecs[0], c);
    #2 reset = 1'b1;
    #1 check("rst_mid_show", {8'hFF, 7'h7F, 1'b1});
    @(negedge clk_in);
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) step("post_rst", vecs[0], c);

    // Value change mid-slot of digit 3 holds until the slot ends
    vm  = mk(32'h0000_3000, 8'hFF, 8'h00, 1'b0, 8'hFF,
             {7'h40,7'h40,7'h40,7'h40,7'h30,7'h40,7'h40,7'h40}, 8'hFF);
    vm2 = mk(32'h0004_4000, 8'hFF, 8'h00, 1'b0, 8'hFF,
             {7'h40,7'h40,7'h40,7'h19,7'h19,7'h40,7'h40,7'h40}, 8'hFF);
    start(vm);
    for (int c = 1; c <= 36; c++) step("mid", vm, c);
    value = 32'h0004_4000;
    for (int c = 37; c <= 40; c++) step("hold", vm, c);
    for (int c = 41; c <= 50; c++) step("next", vm2, c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
